piso_shift_serializer: RTL and testbench
========================================

Name: piso_shift_serializer

Overview:
- Sequential downstream stage for the team's 8-bit shift-right function.
- Accepts a parallel word on a valid/ready handshake and shifts it out one bit per accepted beat, LSB first, right-shifting with zero fill.
- Output beats carry a valid/ready handshake and a last-bit marker, so a bit-serial consumer can apply backpressure.

Parameters:
- DATA_W, 8, width of the parallel input word and number of serial beats per word (minimum 2).
- CNT_W, $clog2(DATA_W+1), width of the internal bit counter (derived; not overridden).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  DATA_W  parallel word to serialize.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle.
- ser_out  output  1  current serial bit.
- ser_valid  output  1  ser_out is valid.
- ser_ready  input  1  consumer accepts ser_out this cycle.
- ser_last  output  1  current beat is the final beat of the word.
- busy  output  1  a word is in flight (state != IDLE).

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset (rst high at a clk edge):
  - state=IDLE; shreg=0; cnt=0.
  - ser_valid=0, ser_out=0, ser_last=0, busy=0.
  - in_ready = (state==IDLE) && !rst, so it is 0 while rst is high.
- Reset mid-word: the word in flight is discarded, with no further beats emitted.
- States:
  - IDLE: in_ready=1.
    - On in_valid && in_ready: shreg<=in_data, cnt<=0, go to SHIFT.
    - in_data is ignored when no handshake occurs.
  - SHIFT: ser_valid=1, ser_out=shreg[0], ser_last=(cnt==DATA_W-1).
    - On ser_valid && ser_ready: shreg<=shreg>>1 (MSB filled with 0), cnt<=cnt+1.
    - If ser_last, go to IDLE (or to PARITY when the optional feature is compiled in).
    - Without ser_ready: shreg, cnt and all outputs hold unchanged.
  - PARITY (optional feature only): see Optional Feature.
- Latency:
  - First bit is valid the cycle after the input handshake.
  - With ser_ready tied high, a word takes DATA_W cycles, followed by one IDLE cycle before the next word is accepted.
  - Sustained throughput is 1 word per DATA_W+1 cycles.
- in_ready is low for the whole of SHIFT/PARITY. in_valid asserted then is held by the upstream stage, not dropped.
- ser_out, ser_valid and ser_last are registered or decoded from registered state only. There is no combinational path from ser_ready or in_valid to any output.
- Counter wrap: cnt never exceeds DATA_W-1 in SHIFT and is cleared on every load.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - Even parity (^in_data) is captured into a register at load.
  - After the DATA_W-th data beat handshakes, the FSM enters PARITY and emits one extra beat: ser_out=parity bit, ser_valid=1, ser_last=1.
  - ser_last is 0 on all data beats.
  - The FSM returns to IDLE on that beat's handshake.
- Undefined: no PARITY state and no parity register; ser_last is asserted on the final data beat.

Decomposition:
- Shared package piso_pkg:
  - state typedef (IDLE, SHIFT, PARITY).
  - default DATA_W constant.
- Sub-module shift_bit_counter (counter with clear, enable and terminal-count flag, width CNT_W).
- Shift register and FSM stay in the top module.

Test Plan:
- Basic: rst 2 cycles, then in_data=8'b10011001 with ser_ready=1 → ser_out sequence 1,0,0,1,1,0,0,1 on cycles 1..8 after the handshake; ser_last only on beat 8; in_ready back to 1 on cycle 9.
- Backpressure: 8'hA5 with ser_ready toggling 1,0,0,1,... → bit sequence 1,0,1,0,0,1,0,1 unchanged; ser_out and ser_last stable while ser_ready=0.
- Busy ignore: present 8'h3C during SHIFT with in_valid held → not accepted until IDLE; then 0,0,1,1,1,1,0,0 follows with no word loss.
- Reset mid-word: assert rst after 3 beats of 8'hFF → next cycle ser_valid=0, busy=0; after release, 8'h01 serializes as 1,0,0,0,0,0,0,0.
- Parity (PISO_PARITY_EN): 8'h07 → data beats 1,1,1,0,0,0,0,0 with ser_last=0, then 9th beat ser_out=1, ser_last=1.
- Parity even: 8'hA5 under the same build → 9th beat ser_out=0.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and defaults for the PISO shift serializer.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam int DATA_W_DEFAULT = 8;

endpackage

// File: rtl/shift_bit_counter.sv
// Beat counter with synchronous clear and enable; flags when the count reaches TERMINAL.
module shift_bit_counter #(
  parameter int CNT_W    = 4,
  parameter int TERMINAL = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == CNT_W'(TERMINAL));

endmodule

// File: rtl/piso_shift_serializer.sv
// Parallel-in serial-out stage: LSB first, zero-fill right shift, valid/ready on both sides.
// Define PISO_PARITY_EN to append an even-parity beat after each word.
module piso_shift_serializer
  import piso_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ser_out,
  output logic              ser_valid,
  input  logic              ser_ready,
  output logic              ser_last,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic              cnt_tc;
  logic              load;
  logic              beat;

  assign in_ready = (state == IDLE) && !rst;
  assign load     = in_valid && in_ready;
  assign beat     = (state == SHIFT) && ser_ready;

  // Cleared on load and again after the final data beat, so the count never reaches DATA_W.
  shift_bit_counter #(
    .CNT_W   (CNT_W),
    .TERMINAL(DATA_W - 1)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clear(load || (beat && cnt_tc)),
    .en   (beat),
    .tc   (cnt_tc)
  );

`ifdef PISO_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      parity_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (load) begin
          shreg    <= in_data;
          parity_q <= ^in_data;
          state    <= SHIFT;
        end
        SHIFT: if (ser_ready) begin
          shreg <= {1'b0, shreg[DATA_W-1:1]};
          if (cnt_tc) state <= PARITY;
        end
        PARITY: if (ser_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign ser_valid = (state == SHIFT) || (state == PARITY);
  assign ser_out   = (state == PARITY) ? parity_q : ((state == SHIFT) && shreg[0]);
  assign ser_last  = (state == PARITY);
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
    end else begin
      case (state)
        IDLE: if (load) begin
          shreg <= in_data;
          state <= SHIFT;
        end
        SHIFT: if (ser_ready) begin
          shreg <= {1'b0, shreg[DATA_W-1:1]};
          if (cnt_tc) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ser_valid = (state == SHIFT);
  assign ser_out   = (state == SHIFT) && shreg[0];
  assign ser_last  = (state == SHIFT) && cnt_tc;
`endif

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_piso_shift_serializer.sv
// Directed bench for piso_shift_serializer; covers reset, backpressure, busy hold, mid-word reset
// and, when PISO_PARITY_EN is defined, the trailing parity beat.
module tb_piso_shift_serializer;

`ifdef PISO_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       ser_out;
  logic       ser_valid;
  logic       ser_ready;
  logic       ser_last;
  logic       busy;

  int checks = 0;
  int errors = 0;

  piso_shift_serializer #(.DATA_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ser_out  (ser_out),
    .ser_valid(ser_valid),
    .ser_ready(ser_ready),
    .ser_last (ser_last),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Present a word and wait (bounded) for the handshake; returns at posedge+1 after it.
  task automatic load_word(input logic [7:0] data);
    int waited = 0;
    in_data  = data;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL load_timeout data=%h in_ready=%b required 1", data, in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Consume one word's beats with a repeating 4-cycle ready pattern; expected bits come from data.
  task automatic serialize_word(input string tag, input logic [7:0] data, input logic [3:0] pat);
    int idx = 0;
    int cyc = 0;
    int total = 8 + PAR;
    logic exp_bit;
    logic exp_last;
    while (idx < total && cyc < 64) begin
      ser_ready = pat[cyc % 4];
      exp_bit   = (idx < 8) ? data[idx] : ^data;
      exp_last  = (idx == total - 1);
      @(negedge clk);
      checks++;
      if (ser_valid !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s_hs beat=%0d valid/busy/in_ready=%b%b%b required 110", tag, idx,
                 ser_valid, busy, in_ready);
      end
      checks++;
      if (ser_out !== exp_bit) begin
        errors++;
        $display("FAIL %s_bit beat=%0d ser_out=%b required %b", tag, idx, ser_out, exp_bit);
      end
      checks++;
      if (ser_last !== exp_last) begin
        errors++;
        $display("FAIL %s_last beat=%0d ser_last=%b required %b", tag, idx, ser_last, exp_last);
      end
      @(posedge clk);
      #1;
      if (ser_ready) idx++;
      cyc++;
    end
    checks++;
    if (idx != total) begin
      errors++;
      $display("FAIL %s_timeout beats=%0d required %0d", tag, idx, total);
    end
    ser_ready = 1'b1;
  endtask

  task automatic expect_idle(input string tag);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || ser_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle in_ready/busy/valid=%b%b%b required 100", tag, in_ready, busy, ser_valid);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    ser_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || ser_valid !== 1'b0 || ser_out !== 1'b0 ||
        ser_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs rdy/busy/valid/out/last=%b%b%b%b%b required 00000",
               in_ready, busy, ser_valid, ser_out, ser_last);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    expect_idle("post_reset");
  endtask

  task automatic test_basic();
    ser_ready = 1'b1;
    @(posedge clk);
    #1;
    load_word(8'b1001_1001);
    serialize_word("basic", 8'b1001_1001, 4'b1111);
    expect_idle("basic");
  endtask

  task automatic test_backpressure();
    @(posedge clk);
    #1;
    load_word(8'hA5);
    serialize_word("bp", 8'hA5, 4'b1001);
    expect_idle("bp");
  endtask

  task automatic test_busy_ignore();
    @(posedge clk);
    #1;
    load_word(8'h81);
    in_data  = 8'h3C;
    in_valid = 1'b1;
    serialize_word("busy_first", 8'h81, 4'b1111);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL busy_reaccept in_ready=%b required 1", in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    serialize_word("busy_second", 8'h3C, 4'b1111);
    expect_idle("busy");
  endtask

  task automatic test_reset_mid_word();
    @(posedge clk);
    #1;
    load_word(8'hFF);
    ser_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (ser_out !== 1'b1 || ser_valid !== 1'b1) begin
        errors++;
        $display("FAIL midrst_beat ser_out/valid=%b%b required 11", ser_out, ser_valid);
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_in_ready in_ready=%b required 0", in_ready);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ser_valid !== 1'b0 || busy !== 1'b0 || ser_out !== 1'b0 || ser_last !== 1'b0) begin
      errors++;
      $display("FAIL midrst_cleared valid/busy/out/last=%b%b%b%b required 0000",
               ser_valid, busy, ser_out, ser_last);
    end
    @(posedge clk);
    #1;
    load_word(8'h01);
    serialize_word("midrst_next", 8'h01, 4'b1111);
    expect_idle("midrst");
  endtask

`ifdef PISO_PARITY_EN
  task automatic test_parity();
    @(posedge clk);
    #1;
    load_word(8'h07);
    serialize_word("par_odd", 8'h07, 4'b1111);
    @(posedge clk);
    #1;
    load_word(8'hA5);
    serialize_word("par_even", 8'hA5, 4'b1011);
    expect_idle("par");
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_busy_ignore();
    test_reset_mid_word();
`ifdef PISO_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
